imem_loader: RTL

Parametrised, synchronous-read instruction memory for the MIPS core, with a streaming program-load port and a registered fetch port. A loader (testbench or boot controller) streams words in with a valid/ready handshake and auto-incrementing write address. The fetch stage reads by byte address with one-cycle latency. It replaces the earlier fixed 1K×32 memory and its shared bidirectional data bus, which had no load sequencing.

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: load-stream and fetch signals of the instruction memory.
// master = loader/fetch side, slave = the memory itself.
interface imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              busy;
    logic              fetch_req;
    logic [ADDR_W+1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_misalign;
    logic              fetch_parity_err;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req, fetch_addr,
        input  load_ready, load_done, load_count, busy,
        input  fetch_valid, fetch_instr, fetch_misalign,
        input  fetch_parity_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req, fetch_addr,
        output load_ready, load_done, load_count, busy,
        output fetch_valid, fetch_instr, fetch_misalign,
        output fetch_parity_err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: instruction memory with streaming load and registered fetch.
// Optional IMEM_PARITY_EN adds a stored even-parity bit per word.
module imem_loader #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 10,
    parameter int unsigned LOAD_BASE = 0
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(LOAD_BASE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
    logic              fetch_misalign_q, fetch_misalign_d;
    logic              fetch_parity_err_q, fetch_parity_err_d;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              accept;
    logic              wr_en;
    logic [MEM_W-1:0]  wr_word;
    logic [ADDR_W-1:0] rd_idx;
    logic [MEM_W-1:0]  rd_word;
    logic              rd_perr;
    logic              fetch_fire;
    logic              misalign;

    assign accept = (state_q == S_LOAD) && bus.load_valid;
    assign wr_en  = accept && !rst;
    assign rd_idx = bus.fetch_addr[ADDR_W+1:2];
    assign rd_word = mem[rd_idx];
    assign misalign = |bus.fetch_addr[1:0];
    assign fetch_fire = bus.fetch_req && (state_q == S_IDLE);

`ifdef IMEM_PARITY_EN
    assign wr_word = {^bus.load_data, bus.load_data};
    assign rd_perr = ^rd_word;
`else
    assign wr_word = bus.load_data;
    assign rd_perr = 1'b0;
`endif

    // Load sequencer: next state, write pointer and beat counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    state_d = S_LOAD;
                    ptr_d   = BASE;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    // Top count bit set means the whole array was filled.
                    if (bus.load_last || count_d[ADDR_W]) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Fetch result: new value only when a request is served in IDLE.
    always_comb begin
        fetch_valid_d      = fetch_fire;
        fetch_instr_d      = fetch_instr_q;
        fetch_misalign_d   = fetch_misalign_q;
        fetch_parity_err_d = fetch_parity_err_q;
        if (fetch_fire) begin
            fetch_misalign_d   = misalign;
            fetch_instr_d      = misalign ? '0 : rd_word[DATA_W-1:0];
            fetch_parity_err_d = !misalign && rd_perr;
        end
    end

    // Control and fetch output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            ptr_q              <= '0;
            count_q            <= '0;
            fetch_valid_q      <= 1'b0;
            fetch_instr_q      <= '0;
            fetch_misalign_q   <= 1'b0;
            fetch_parity_err_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            ptr_q              <= ptr_d;
            count_q            <= count_d;
            fetch_valid_q      <= fetch_valid_d;
            fetch_instr_q      <= fetch_instr_d;
            fetch_misalign_q   <= fetch_misalign_d;
            fetch_parity_err_q <= fetch_parity_err_d;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= wr_word;
        end
    end

    assign bus.load_ready       = (state_q == S_LOAD);
    assign bus.load_done        = (state_q == S_DONE);
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.load_count       = count_q;
    assign bus.fetch_valid      = fetch_valid_q;
    assign bus.fetch_instr      = fetch_instr_q;
    assign bus.fetch_misalign   = fetch_misalign_q;
    assign bus.fetch_parity_err = fetch_parity_err_q;
endmodule
